// File: rtl/types_pkg.sv
// Shared types for the ID/EX stage: data bus, ALU operation codes,
// register index type, the pipelined control bundle and forwarding selects.
package types_pkg;

   localparam int DATA_BUS_W = 32;
   localparam int REG_ADDR_W = 5;

   typedef logic [DATA_BUS_W-1:0] DATA_BUS;
   typedef logic [REG_ADDR_W-1:0] REG_ADDR;

   typedef enum logic [1:0] {
      SUM_OP = 2'd0,
      SUB_OP = 2'd1,
      AND_OP = 2'd2,
      SLT_OP = 2'd3
   } alu_ctrl;

   typedef struct packed {
      logic    reg_write;
      logic    mem_read;
      logic    mem_write;
      logic    alu_src;
      alu_ctrl alu_op;
   } id_ex_ctrl_t;

   typedef enum logic [1:0] {
      FWD_REG = 2'd0,
      FWD_MEM = 2'd1,
      FWD_WB  = 2'd2
   } fwd_sel_t;

   localparam id_ex_ctrl_t CTRL_RESET = '{
      reg_write: 1'b0,
      mem_read:  1'b0,
      mem_write: 1'b0,
      alu_src:   1'b0,
      alu_op:    SUM_OP
   };

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// Chooses the source of one EX operand: the MEM result, the WB result or
// the registered read data. The MEM stage holds the younger value, so it wins.
module forward_unit
   import types_pkg::*;
#(
   parameter int ADDR_WIDTH = 5
) (
   input  logic [ADDR_WIDTH-1:0] rs,
   input  logic [ADDR_WIDTH-1:0] mem_rd,
   input  logic                  mem_reg_write,
   input  logic [ADDR_WIDTH-1:0] wb_rd,
   input  logic                  wb_reg_write,
   output fwd_sel_t              sel
);

   always_comb begin
      sel = FWD_REG;
      if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs)) begin
         sel = FWD_MEM;
      end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs)) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, bubble insertion,
// WB write-through at capture and MEM/WB forwarding into the ALU operands.
module id_ex_stage
   import types_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [ADDR_WIDTH-1:0] id_rs1,
   input  logic [ADDR_WIDTH-1:0] id_rs2,
   input  logic [ADDR_WIDTH-1:0] id_rd,
   input  logic [DATA_WIDTH-1:0] id_rd1,
   input  logic [DATA_WIDTH-1:0] id_rd2,
   input  logic [DATA_WIDTH-1:0] id_imm,
   input  logic                  id_alu_src,
   input  alu_ctrl               id_alu_ctrl,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  id_mem_write,
   input  logic                  flush,
   input  logic                  ex_hold,
   input  logic [ADDR_WIDTH-1:0] mem_rd,
   input  logic                  mem_reg_write,
   input  logic [DATA_WIDTH-1:0] mem_result,
   input  logic [ADDR_WIDTH-1:0] wb_rd,
   input  logic                  wb_reg_write,
   input  logic [DATA_WIDTH-1:0] wb_result,
   output logic                  stall,
   output logic                  ex_valid,
   output DATA_BUS               alu_op1,
   output DATA_BUS               alu_op2,
   output alu_ctrl               alu_ctrl_o,
   output DATA_BUS               ex_store_data,
   output logic [ADDR_WIDTH-1:0] ex_rd,
   output logic                  ex_reg_write,
   output logic                  ex_mem_read,
   output logic                  ex_mem_write
);

   logic                  ex_valid_q, ex_valid_d;
   id_ex_ctrl_t           ctrl_q, ctrl_d;
   logic [ADDR_WIDTH-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic [DATA_WIDTH-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
   logic                  load_use;
   fwd_sel_t              sel1, sel2;
   logic [DATA_WIDTH-1:0] fwd_rs1, fwd_rs2;

   assign load_use = ex_valid_q && ctrl_q.mem_read && (rd_q != '0)
                     && ((rd_q == id_rs1) || (rd_q == id_rs2)) && id_valid;
   assign stall    = load_use || ex_hold;

   always_comb begin
      ex_valid_d = ex_valid_q;
      ctrl_d     = ctrl_q;
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      rd_d       = rd_q;
      rd1_d      = rd1_q;
      rd2_d      = rd2_q;
      imm_d      = imm_q;
      if (flush || (!ex_hold && load_use)) begin
         ex_valid_d       = 1'b0;
         ctrl_d.reg_write = 1'b0;
         ctrl_d.mem_read  = 1'b0;
         ctrl_d.mem_write = 1'b0;
      end else if (!ex_hold) begin
         ex_valid_d       = id_valid;
         ctrl_d.reg_write = id_reg_write;
         ctrl_d.mem_read  = id_mem_read;
         ctrl_d.mem_write = id_mem_write;
         ctrl_d.alu_src   = id_alu_src;
         ctrl_d.alu_op    = id_alu_ctrl;
         rs1_d            = id_rs1;
         rs2_d            = id_rs2;
         rd_d             = id_rd;
         imm_d            = id_imm;
         // The register file is written at the same edge, so its read data is stale.
         rd1_d = (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs1)) ? wb_result : id_rd1;
         rd2_d = (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs2)) ? wb_result : id_rd2;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_valid_q <= 1'b0;
         ctrl_q     <= CTRL_RESET;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         rd1_q      <= '0;
         rd2_q      <= '0;
         imm_q      <= '0;
      end else begin
         ex_valid_q <= ex_valid_d;
         ctrl_q     <= ctrl_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         rd_q       <= rd_d;
         rd1_q      <= rd1_d;
         rd2_q      <= rd2_d;
         imm_q      <= imm_d;
      end
   end

   forward_unit #(.ADDR_WIDTH(ADDR_WIDTH)) u_fwd_rs1 (
      .rs            (rs1_q),
      .mem_rd        (mem_rd),
      .mem_reg_write (mem_reg_write),
      .wb_rd         (wb_rd),
      .wb_reg_write  (wb_reg_write),
      .sel           (sel1)
   );

   forward_unit #(.ADDR_WIDTH(ADDR_WIDTH)) u_fwd_rs2 (
      .rs            (rs2_q),
      .mem_rd        (mem_rd),
      .mem_reg_write (mem_reg_write),
      .wb_rd         (wb_rd),
      .wb_reg_write  (wb_reg_write),
      .sel           (sel2)
   );

   always_comb begin
      unique case (sel1)
         FWD_MEM: fwd_rs1 = mem_result;
         FWD_WB:  fwd_rs1 = wb_result;
         default: fwd_rs1 = rd1_q;
      endcase
      unique case (sel2)
         FWD_MEM: fwd_rs2 = mem_result;
         FWD_WB:  fwd_rs2 = wb_result;
         default: fwd_rs2 = rd2_q;
      endcase
   end

   assign ex_valid      = ex_valid_q;
   assign alu_op1       = fwd_rs1;
   assign alu_op2       = ctrl_q.alu_src ? imm_q : fwd_rs2;
   assign ex_store_data = fwd_rs2;
   assign alu_ctrl_o    = ctrl_q.alu_op;
   assign ex_rd         = rd_q;
   assign ex_reg_write  = ex_valid_q && ctrl_q.reg_write;
   assign ex_mem_read   = ex_valid_q && ctrl_q.mem_read;
   assign ex_mem_write  = ex_valid_q && ctrl_q.mem_write;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-select stage, directly upstream of the ALU.
- Captures decoded control and register-file read data from decode.
- Resolves data hazards:
  - forwards MEM and WB results into the ALU operands;
  - detects load-use hazards, stalls decode and inserts a bubble.
- Drives alu_op1/alu_op2/alu_ctrl straight into the ALU.

Parameters:
- DATA_WIDTH, 32, operand/result width; must match DATA_BUS in types_pkg.
- ADDR_WIDTH, 5, register index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  decode holds a real instruction
- id_rs1, id_rs2, id_rd  in  ADDR_WIDTH each  source/dest register indices
- id_rd1, id_rd2  in  DATA_WIDTH  register-file read data
- id_imm  in  DATA_WIDTH  sign-extended immediate
- id_alu_src  in  1  1: op2 = immediate
- id_alu_ctrl  in  alu_ctrl  ALU operation
- id_reg_write, id_mem_read, id_mem_write  in  1 each  control
- flush  in  1  branch taken; kill the instruction entering EX
- ex_hold  in  1  downstream busy; freeze this stage
- mem_rd  in  ADDR_WIDTH  dest of the instruction in MEM
- mem_reg_write  in  1  write enable of the instruction in MEM
- mem_result  in  DATA_WIDTH  result of the instruction in MEM
- wb_rd  in  ADDR_WIDTH  dest of the instruction in WB
- wb_reg_write  in  1  write enable of the instruction in WB
- wb_result  in  DATA_WIDTH  result of the instruction in WB
- stall  out  1  hold PC and IF/ID
- ex_valid  out  1  EX holds a real instruction
- alu_op1, alu_op2  out  DATA_BUS  forwarded ALU operands
- alu_ctrl_o  out  alu_ctrl  registered ALU operation
- ex_store_data  out  DATA_BUS  forwarded rs2 value
- ex_rd  out  ADDR_WIDTH  registered destination index
- ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  registered control, gated by ex_valid

Behaviour:
- Reset (rst_n=0 at posedge): all registered fields = 0, ex_valid = 0, alu_ctrl_o = SUM_OP. Reset overrides every other input.
- Register update priority at each posedge: rst_n=0 > flush (bubble: ex_valid=0, write enables=0) > ex_hold (all fields keep value) > load_use (bubble) > normal capture.
- load_use (combinational): ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2) & id_valid.
- stall = load_use | ex_hold, combinational, same cycle.
- A bubble is inserted for exactly one cycle; the held decode instruction is captured on the next edge.
- Normal capture, 1-cycle latency: every id_* field is registered; ex_valid <= id_valid.
- WB write-through at capture: if wb_reg_write & wb_rd!=0 & wb_rd==id_rsX, capture wb_result instead of id_rdX.
- Forwarding (combinational on the registered rs1/rs2), per source X:
  - mem_reg_write & mem_rd!=0 & mem_rd==ex_rsX → mem_result;
  - else wb_reg_write & wb_rd!=0 & wb_rd==ex_rsX → wb_result;
  - else the registered value. MEM takes priority over WB.
- Register x0 is never forwarded and always reads its registered value.
- alu_op1 = fwd_rs1.
- alu_op2 = ex_alu_src ? ex_imm : fwd_rs2.
- ex_store_data = fwd_rs2 (always forwarded, independent of alu_src).
- When ex_valid=0, the ex_reg_write/ex_mem_read/ex_mem_write outputs are 0. Operand values are don't-care but must not be X after reset.
- Simultaneous flush + load_use: flush wins; stall still asserts for load_use.
- Simultaneous flush + ex_hold: flush wins.
- Reset asserted mid-stall: next cycle stall=0.

Decomposition:
- Put in types_pkg: DATA_BUS, alu_ctrl (SUM_OP/SUB_OP/AND_OP/SLT_OP), a REG_ADDR typedef, and a packed struct id_ex_ctrl_t bundling reg_write/mem_read/mem_write/alu_src/alu_ctrl.
- Sub-module: forward_unit, purely combinational. It takes the rs indices and the MEM/WB destinations, and outputs a 2-bit select per operand. It is instantiated once per operand.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with id_valid=1 → ex_valid=0, stall=0, alu_op1=alu_op2=0; first capture happens on the first edge with rst_n=1.
- Basic add: id_rd1=5, id_rd2=7, alu_src=0, SUM_OP → next cycle alu_op1=5, alu_op2=7. With alu_src=1, id_imm=0xFFFFFFFC → alu_op2=0xFFFFFFFC, ex_store_data=7.
- Forward priority: ex_rs1=3, mem_rd=wb_rd=3, mem_result=0x11, wb_result=0x22 → alu_op1=0x11. With mem_reg_write=0 → 0x22. With rs1=rd=0 → registered value.
- Load-use: EX holds a load with rd=4, ID rs2=4 → stall=1 in the same cycle; next cycle ex_valid=0 and stall=0; the following cycle the instruction is captured.
- Flush vs hazard: flush=1 with load_use=1 → next cycle ex_valid=0; ex_hold=1 alone → all outputs unchanged for 3 cycles.
- Write-through: id_rs1=6, id_rd1=0, wb_rd=6, wb_reg_write=1, wb_result=0xAB at the capture edge → alu_op1=0xAB the next cycle, with no MEM/WB match then.
